// File: rtl/aibnd_dcc_cal_ctrl_if.sv
// Signal bundle between the DLL/phase-detector side and the DCC calibration controller.
// The controller attaches through the slave modport; the driving side uses master.
interface aibnd_dcc_cal_ctrl_if #(
    parameter int GRAY_W = 10,
    parameter int I_W    = 3
);
    logic                  dll_lock;
    logic [I_W-1:0]        i_gray;
    logic [GRAY_W-I_W-1:0] f_gray;
    logic [GRAY_W-1:0]     pvt_ref_half_gry;
    logic                  rb_cont_cal;
    logic                  rb_dcc_byp;
    logic                  t_up;
    logic                  t_down;
    logic                  scan_mode_n;
    logic                  scan_shift_n;
    logic                  scan_in;
    logic [GRAY_W-1:0]     dly_gray;
    logic                  dly_sel_cont;
    logic                  dcc_done;
    logic                  track_sat;
    logic [2:0]            cal_state;
    logic                  scan_out;

    modport master (
        output dll_lock, i_gray, f_gray, pvt_ref_half_gry, rb_cont_cal, rb_dcc_byp,
               t_up, t_down, scan_mode_n, scan_shift_n, scan_in,
        input  dly_gray, dly_sel_cont, dcc_done, track_sat, cal_state, scan_out
    );

    modport slave (
        input  dll_lock, i_gray, f_gray, pvt_ref_half_gry, rb_cont_cal, rb_dcc_byp,
               t_up, t_down, scan_mode_n, scan_shift_n, scan_in,
        output dly_gray, dly_sel_cont, dcc_done, track_sat, cal_state, scan_out
    );
endinterface

// File: rtl/aibnd_dcc_cal_ctrl.sv
// Duty-cycle-correction calibration controller: loads a half-period reference code on
// DLL lock, waits for settling, then optionally tracks phase-detector votes.
module aibnd_dcc_cal_ctrl #(
    parameter int GRAY_W   = 10,
    parameter int I_W      = 3,
    parameter int DONE_DLY = 7,
    parameter int TRACK_TH = 4
) (
    input  logic                  clk_dcd,
    input  logic                  dll_reset,
    aibnd_dcc_cal_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        DONE      = 3'd3,
        TRACK     = 3'd4,
        BYP       = 3'd5
    } state_t;

    localparam int CNT_W = (DONE_DLY < 2) ? 1 : $clog2(DONE_DLY + 1);
    localparam logic signed [3:0] TH_P = 4'(TRACK_TH);
    localparam logic signed [3:0] TH_N = 4'(-TRACK_TH);

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int k = GRAY_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    state_t                   state_q, state_d;
    logic [GRAY_W-1:0]        code_q, code_d;
    logic signed [3:0]        filt_q, filt_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     sat_q, sat_d;
    logic [GRAY_W-1:0]        dly_gray_q, dly_gray_d;
    logic                     done_q, done_d;
    logic                     sel_cont_q, sel_cont_d;
    logic signed [3:0]        filt_inc, filt_dec;
    logic                     scan_frz;
    logic                     locked_state;

    assign scan_frz     = ~bus.scan_mode_n & ~bus.scan_shift_n;
    assign locked_state = (state_q == SETTLE) || (state_q == DONE) || (state_q == TRACK);
    assign filt_inc     = filt_q + 4'sd1;
    assign filt_dec     = filt_q - 4'sd1;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;

        if (scan_frz) begin
            // Freeze: only the code register moves, acting as the scan chain.
            code_d = {code_q[GRAY_W-2:0], bus.scan_in};
        end else if (bus.rb_dcc_byp) begin
            state_d = BYP;
            cnt_d   = '0;
            filt_d  = '0;
        end else if (!bus.dll_lock && locked_state) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            filt_d  = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    if (bus.dll_lock) begin
                        code_d  = gray2bin(bus.pvt_ref_half_gry);
                        filt_d  = '0;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DONE_DLY - 1)) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.rb_cont_cal) begin
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (!bus.rb_cont_cal) begin
                        state_d = DONE;
                        filt_d  = '0;
                    end else if (bus.t_up && !bus.t_down) begin
                        if (filt_inc == TH_P) begin
                            filt_d = '0;
                            if (code_q == '1) sat_d = 1'b1;
                            else              code_d = code_q + 1'b1;
                        end else begin
                            filt_d = filt_inc;
                        end
                    end else if (bus.t_down && !bus.t_up) begin
                        if (filt_dec == TH_N) begin
                            filt_d = '0;
                            if (code_q == '0) sat_d = 1'b1;
                            else              code_d = code_q - 1'b1;
                        end else begin
                            filt_d = filt_dec;
                        end
                    end
                end
                BYP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if ((state_q == TRACK) && (state_d != TRACK)) begin
            sat_d = 1'b0;
        end
    end

    // Status outputs are registered against the next state so they align with cal_state.
    always_comb begin
        done_d     = (state_d == DONE) || (state_d == TRACK) || (state_d == BYP);
        sel_cont_d = (state_d == TRACK);
        case (state_q)
            WAIT_LOCK:            dly_gray_d = {bus.f_gray, bus.i_gray};
            SETTLE, DONE, TRACK:  dly_gray_d = bin2gray(code_q);
            default:              dly_gray_d = '0;
        endcase
    end

    always_ff @(posedge clk_dcd) begin
        if (dll_reset) begin
            state_q    <= IDLE;
            code_q     <= '0;
            filt_q     <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            dly_gray_q <= '0;
            done_q     <= 1'b0;
            sel_cont_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            dly_gray_q <= dly_gray_d;
            done_q     <= done_d;
            sel_cont_q <= sel_cont_d;
        end
    end

    assign bus.dly_gray     = dly_gray_q;
    assign bus.dly_sel_cont = sel_cont_q;
    assign bus.dcc_done     = done_q;
    assign bus.track_sat    = sat_q;
    assign bus.cal_state    = state_q;
    assign bus.scan_out     = code_q[GRAY_W-1];

endmodule

// File: tb/tb_aibnd_dcc_cal_ctrl.sv
// Directed bench for the DCC calibration controller: lock flow, tracking, saturation,
// lock loss, scan shift, reset mid-settle and bypass.
module tb_aibnd_dcc_cal_ctrl;

    logic clk_dcd   = 1'b0;
    logic dll_reset = 1'b1;
    int   n_vec     = 0;
    int   n_err     = 0;

    aibnd_dcc_cal_ctrl_if #(.GRAY_W(10), .I_W(3)) bus ();

    aibnd_dcc_cal_ctrl #(
        .GRAY_W(10), .I_W(3), .DONE_DLY(7), .TRACK_TH(4)
    ) dut (
        .clk_dcd   (clk_dcd),
        .dll_reset (dll_reset),
        .bus       (bus)
    );

    always #5 clk_dcd = ~clk_dcd;

    task automatic tick();
        @(posedge clk_dcd);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    logic       sin_v [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [9:0] prev_v     = 10'h081;

    initial begin
        bus.dll_lock         = 1'b0;
        bus.i_gray           = 3'b101;
        bus.f_gray           = 7'h12;
        bus.pvt_ref_half_gry = 10'h000;
        bus.rb_cont_cal      = 1'b0;
        bus.rb_dcc_byp       = 1'b0;
        bus.t_up             = 1'b0;
        bus.t_down           = 1'b0;
        bus.scan_mode_n      = 1'b1;
        bus.scan_shift_n     = 1'b1;
        bus.scan_in          = 1'b0;

        // Reset values
        tick();
        tick();
        check_val("rst_dly_gray", 32'(bus.dly_gray), 32'h0);
        check_val("rst_done", 32'(bus.dcc_done), 32'h0);
        check_val("rst_sel", 32'(bus.dly_sel_cont), 32'h0);
        check_val("rst_sat", 32'(bus.track_sat), 32'h0);
        check_val("rst_state", 32'(bus.cal_state), 32'h0);
        check_val("rst_scan_out", 32'(bus.scan_out), 32'h0);

        // Lock flow
        dll_reset = 1'b0;
        tick();
        check_val("wait_state", 32'(bus.cal_state), 32'h1);
        tick();
        check_val("wait_dly_gray", 32'(bus.dly_gray), 32'h095);
        bus.pvt_ref_half_gry = 10'h0C0;
        bus.dll_lock         = 1'b1;
        tick();
        check_val("settle_state", 32'(bus.cal_state), 32'h2);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) check_val("settle_dly_gray", 32'(bus.dly_gray), 32'h0C0);
            check_val($sformatf("settle_done_%0d", k), 32'(bus.dcc_done), 32'(k == 7));
        end
        check_val("done_state", 32'(bus.cal_state), 32'h3);

        // Tracking up, hold, down
        bus.rb_cont_cal = 1'b1;
        tick();
        check_val("track_state", 32'(bus.cal_state), 32'h4);
        check_val("track_sel", 32'(bus.dly_sel_cont), 32'h1);
        bus.t_up = 1'b1;
        repeat (8) tick();
        bus.t_up = 1'b0;
        tick();
        check_val("track_up_gray", 32'(bus.dly_gray), 32'h0C3);
        bus.t_up   = 1'b1;
        bus.t_down = 1'b1;
        repeat (8) tick();
        bus.t_up   = 1'b0;
        bus.t_down = 1'b0;
        tick();
        check_val("track_both_hold", 32'(bus.dly_gray), 32'h0C3);
        bus.t_down = 1'b1;
        repeat (4) tick();
        bus.t_down = 1'b0;
        tick();
        check_val("track_down_gray", 32'(bus.dly_gray), 32'h0C1);
        bus.t_up = 1'b1;
        repeat (3) tick();
        bus.t_up   = 1'b0;
        bus.t_down = 1'b1;
        repeat (3) tick();
        bus.t_down = 1'b0;
        tick();
        check_val("track_subth_hold", 32'(bus.dly_gray), 32'h0C1);

        bus.rb_cont_cal = 1'b0;
        tick();
        check_val("untrack_state", 32'(bus.cal_state), 32'h3);
        check_val("untrack_sel", 32'(bus.dly_sel_cont), 32'h0);
        check_val("untrack_done", 32'(bus.dcc_done), 32'h1);

        // Scan shift: prior code 0x081 out MSB-first, then 0x281 loaded
        bus.scan_mode_n  = 1'b0;
        bus.scan_shift_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.scan_in = sin_v[k];
            check_val($sformatf("scan_prior_%0d", k), 32'(bus.scan_out), 32'(prev_v[9-k]));
            tick();
        end
        check_val("scan_frz_state", 32'(bus.cal_state), 32'h3);
        check_val("scan_frz_done", 32'(bus.dcc_done), 32'h1);
        bus.scan_mode_n  = 1'b1;
        bus.scan_shift_n = 1'b1;
        tick();
        check_val("scan_loaded_gray", 32'(bus.dly_gray), 32'h3C1);
        bus.scan_mode_n  = 1'b0;
        bus.scan_shift_n = 1'b0;
        bus.scan_in      = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_val($sformatf("scan_echo_%0d", k), 32'(bus.scan_out), 32'(sin_v[k]));
            tick();
        end
        bus.scan_mode_n  = 1'b1;
        bus.scan_shift_n = 1'b1;

        // Lock loss while tracking
        bus.rb_cont_cal = 1'b1;
        tick();
        check_val("ll_track_state", 32'(bus.cal_state), 32'h4);
        bus.i_gray   = 3'b010;
        bus.f_gray   = 7'h55;
        bus.dll_lock = 1'b0;
        tick();
        check_val("ll_state", 32'(bus.cal_state), 32'h1);
        check_val("ll_done", 32'(bus.dcc_done), 32'h0);
        check_val("ll_sel", 32'(bus.dly_sel_cont), 32'h0);
        tick();
        check_val("ll_dly_gray", 32'(bus.dly_gray), 32'h2AA);

        // Saturation at the top code
        bus.pvt_ref_half_gry = 10'h200;
        bus.dll_lock         = 1'b1;
        tick();
        repeat (7) tick();
        check_val("sat_done_state", 32'(bus.cal_state), 32'h3);
        tick();
        check_val("sat_track_state", 32'(bus.cal_state), 32'h4);
        check_val("sat_pre", 32'(bus.track_sat), 32'h0);
        bus.t_up = 1'b1;
        repeat (4) tick();
        bus.t_up = 1'b0;
        check_val("sat_set", 32'(bus.track_sat), 32'h1);
        tick();
        check_val("sat_code_gray", 32'(bus.dly_gray), 32'h200);
        bus.rb_cont_cal = 1'b0;
        tick();
        check_val("sat_clear", 32'(bus.track_sat), 32'h0);
        check_val("sat_exit_state", 32'(bus.cal_state), 32'h3);

        // Reset in the third settle cycle, then full relock
        bus.dll_lock = 1'b0;
        tick();
        bus.pvt_ref_half_gry = 10'h0C0;
        bus.dll_lock         = 1'b1;
        repeat (3) tick();
        check_val("mid_settle_state", 32'(bus.cal_state), 32'h2);
        dll_reset = 1'b1;
        tick();
        dll_reset = 1'b0;
        check_val("midrst_state", 32'(bus.cal_state), 32'h0);
        check_val("midrst_dly_gray", 32'(bus.dly_gray), 32'h0);
        check_val("midrst_done", 32'(bus.dcc_done), 32'h0);
        check_val("midrst_scan_out", 32'(bus.scan_out), 32'h0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_val($sformatf("relock_done_%0d", k), 32'(bus.dcc_done), 32'(k == 9));
        end

        // Bypass
        bus.rb_dcc_byp = 1'b1;
        tick();
        check_val("byp_state", 32'(bus.cal_state), 32'h5);
        check_val("byp_done", 32'(bus.dcc_done), 32'h1);
        tick();
        check_val("byp_dly_gray", 32'(bus.dly_gray), 32'h0);
        bus.rb_dcc_byp = 1'b0;
        tick();
        check_val("byp_exit_state", 32'(bus.cal_state), 32'h0);
        check_val("byp_exit_done", 32'(bus.dcc_done), 32'h0);

        // Reset wins over scan freeze
        repeat (10) tick();
        bus.scan_mode_n  = 1'b0;
        bus.scan_shift_n = 1'b0;
        bus.scan_in      = 1'b1;
        dll_reset        = 1'b1;
        tick();
        check_val("rst_frz_state", 32'(bus.cal_state), 32'h0);
        check_val("rst_frz_scan_out", 32'(bus.scan_out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aibnd_dcc_cal_ctrl.md
AIBND_DCC_CAL_CTRL -- requirements
Module: aibnd_dcc_cal_ctrl

Interface
REQ-001 Parameter GRAY_W, default 10, width of the delay-line gray code.
REQ-002 Parameter I_W, default 3, integer-code width; fine-code width is GRAY_W-I_W.
REQ-003 Parameter DONE_DLY, default 7, number of settle cycles before dcc_done.
REQ-004 Parameter TRACK_TH, default 4, tracking filter threshold, in the range 1..7.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports (name, direction, width, meaning):
- clk_dcd, in, 1: sole clock; all flops rising-edge.
- dll_reset, in, 1: synchronous active-high reset.
- dll_lock, in, 1: DLL lock level.
- i_gray, in, I_W: DLL integer code.
- f_gray, in, GRAY_W-I_W: DLL fine code.
- pvt_ref_half_gry, in, GRAY_W: half-period reference code, gray-coded.
- rb_cont_cal, in, 1: continuous-calibration enable.
- rb_dcc_byp, in, 1: DCC bypass.
- t_up / t_down, in, 1 each: phase-detector votes.
- scan_mode_n / scan_shift_n / scan_in, in, 1 each: scan control and data.
- dly_gray, out, GRAY_W: registered delay-line code.
- dly_sel_cont, out, 1: selects the continuous delay path.
- dcc_done, out, 1: calibration complete.
- track_sat, out, 1: sticky flag, tracking hit a code limit.
- cal_state, out, 3: FSM state.
- scan_out, out, 1: scan chain output.

Function
REQ-007 FSM state encodings: IDLE=0, WAIT_LOCK=1, SETTLE=2, DONE=3, TRACK=4, BYP=5.
REQ-008 State-control priority, highest first: dll_reset; scan freeze; rb_dcc_byp; dll_lock loss; normal transitions.
REQ-009 Scan freeze is active when scan_mode_n=0 and scan_shift_n=0.
- FSM, filter and sticky flags hold.
- code_bin shifts one place per cycle: scan_in->bit0, bit k->bit k+1.
- scan_out = code_bin[GRAY_W-1] at all times.
REQ-010 IDLE goes to WAIT_LOCK on the next cycle.
REQ-011 In WAIT_LOCK, with dll_lock=1:
- code_bin <= gray2bin(pvt_ref_half_gry).
- filter <= 0.
- next state is SETTLE.
REQ-012 SETTLE counts DONE_DLY cycles, then goes to DONE.
- The first SETTLE cycle counts as 1.
- dcc_done rises on the cycle DONE is entered.
REQ-013 DONE goes to TRACK when rb_cont_cal=1; TRACK goes to DONE when rb_cont_cal=0 (filter cleared, code held).
REQ-014 When dll_lock=0 in SETTLE, DONE or TRACK, the next state is WAIT_LOCK.
- Settle count, filter and track_sat are cleared.
- code_bin is held.
REQ-015 When rb_dcc_byp=1 in any state, the next state is BYP.
- BYP leaves to IDLE when rb_dcc_byp=0.
REQ-016 dcc_done is registered and equals 1 exactly in states DONE, TRACK and BYP.
REQ-017 dly_sel_cont is registered and equals 1 exactly in TRACK.
REQ-018 dly_gray source, selected by current state, registered (one-cycle latency):
- IDLE, BYP: 0.
- WAIT_LOCK: {f_gray, i_gray}, with i_gray in the LSBs.
- SETTLE, DONE, TRACK: bin2gray(code_bin).
REQ-019 Tracking filter: signed 4-bit register, updated in TRACK only.
- t_up & ~t_down: +1.
- t_down & ~t_up: -1.
- Both or neither: hold.
REQ-020 Filter threshold actions:
- Filter reaches +TRACK_TH: code_bin +1, filter cleared the same cycle.
- Filter reaches -TRACK_TH: code_bin -1, filter cleared the same cycle.
REQ-021 code_bin saturates at 2^GRAY_W-1 and at 0.
- A step that would cross a limit leaves the code unchanged and sets track_sat.
- track_sat clears on leaving TRACK or on reset.
REQ-022 gray2bin and bin2gray are standard reflected-binary conversions; bin2gray(b) = b ^ (b>>1).

Reset
REQ-023 While dll_reset=1 at a clock edge, the following take their reset values:
- state = IDLE.
- code_bin, filter, settle count = 0.
- dly_gray = 0.
- dcc_done, dly_sel_cont, track_sat = 0.
- cal_state = 0.
- scan_out = 0.
REQ-024 dll_reset overrides scan freeze and takes effect mid-operation in any state, with no partial update.

Verification (GRAY_W=10, I_W=3, DONE_DLY=7, TRACK_TH=4)
REQ-025 Lock flow: reset; i_gray=3'b101, f_gray=7'h12 -> dly_gray=10'h095.
- Then pvt_ref_half_gry=10'h0C0, dll_lock=1 -> code_bin=10'h080 and dly_gray=10'h0C0.
- dcc_done=1 exactly 7 cycles after SETTLE entry; cal_state=3.
REQ-026 Track up: from REQ-025 state, rb_cont_cal=1, then t_up=1 for 8 cycles -> code_bin=10'h082, dly_gray=10'h0C3, dly_sel_cont=1.
- t_up=t_down=1 for 8 further cycles -> no change.
REQ-027 Saturation: lock with pvt_ref_half_gry=10'h200 (code 10'h3FF), TRACK, t_up=1 for 4 cycles -> code stays 10'h3FF, track_sat=1.
- rb_cont_cal=0 -> track_sat=0.
REQ-028 Lock loss in TRACK: dll_lock=0 -> next cycle cal_state=1, dcc_done=0, dly_sel_cont=0, dly_gray follows {f_gray, i_gray}.
REQ-029 Scan: scan_mode_n=0, scan_shift_n=0, shift 10 bits 1,0,1,0,0,0,0,0,0,1 -> scan_out emits the prior code_bin MSB-first, then reproduces the input after 10 cycles.
- FSM is frozen throughout.
REQ-030 Reset mid-SETTLE at cycle 3 -> next cycle all outputs at reset values.
- dcc_done does not assert until a full relock completes.
